// File: rtl/i2c_slave.sv
// i2c_slave: byte-oriented I2C target.
//   Oversamples sclk/sda with clk, detects START / repeated START / STOP, matches a 7-bit
//   address, ACKs the address and every written byte, and fetches read bytes from local logic.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   sclk        bus clock from the master
//   sda         open-drain bus data (driven 0 or z only)
//   rx_data     last data byte written by the master, qualified by the rx_valid pulse
//   tx_data     byte to return on reads, captured while tx_load pulses
//   busy        START seen and no STOP yet
//   addressed   this target has ACKed its address in the current transfer
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h77,
  parameter bit         LSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       addressed
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAddr    = 3'd1;
  localparam logic [2:0] StAddrAck = 3'd2;
  localparam logic [2:0] StRx      = 3'd3;
  localparam logic [2:0] StRxAck   = 3'd4;
  localparam logic [2:0] StTx      = 3'd5;
  localparam logic [2:0] StTxAck   = 3'd6;

  // Bus front end: two synchronizer stages plus the previous synchronized sample.
  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_done_q, byte_done_d;  // byte complete, ACK drive waits for the next fall
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       addressed_q, addressed_d;

  logic       sclk_rise, sclk_fall, sclk_high;
  logic       start_det, stop_det;
  logic [7:0] shift_in;

  function automatic logic tx_bit(input logic [7:0] v);
    return LSB_FIRST ? v[0] : v[7];
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] v);
    return LSB_FIRST ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Idle bus level so that leaving reset creates no false edges.
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_prev_q  <= 1'b1;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sda_s1_q    <= sda;
      sda_s2_q    <= sda_s1_q;
      sda_prev_q  <= sda_s2_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  // Requiring sclk high in both samples makes any sclk edge win over START/STOP.
  assign sclk_high = sclk_s2_q & sclk_prev_q;
  assign start_det = sclk_high & sda_prev_q & ~sda_s2_q;
  assign stop_det  = sclk_high & ~sda_prev_q & sda_s2_q;
  assign shift_in  = LSB_FIRST ? {sda_s2_q, shreg_q[7:1]} : {shreg_q[6:0], sda_s2_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    if (stop_det) begin
      state_d     = StIdle;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else if (start_det) begin
      state_d     = StAddr;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: begin
          if (sclk_rise) begin
            shreg_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                byte_done_d = 1'b1;
                rw_d        = shift_in[0];
              end else begin
                state_d = StIdle;
              end
            end
          end else if (sclk_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            addressed_d = 1'b1;
            state_d     = StAddrAck;
          end
        end
        StAddrAck: begin
          if (sclk_fall) begin
            cnt_d = 3'd0;
            if (rw_q) begin
              shreg_d   = tx_data;
              tx_load_d = 1'b1;
              sda_oe_d  = ~tx_bit(tx_data);
              state_d   = StTx;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StRx;
            end
          end
        end
        StRx: begin
          if (sclk_rise) begin
            shreg_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d   = shift_in;
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end else if (sclk_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = StRxAck;
          end
        end
        StRxAck: begin
          if (sclk_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StRx;
          end
        end
        StTx: begin
          if (sclk_fall) begin
            if (cnt_q == 3'd7) begin
              cnt_d    = 3'd0;
              sda_oe_d = 1'b0;
              state_d  = StTxAck;
            end else begin
              cnt_d    = cnt_q + 3'd1;
              shreg_d  = tx_shift(shreg_q);
              sda_oe_d = ~tx_bit(tx_shift(shreg_q));
            end
          end
        end
        StTxAck: begin
          if (sclk_rise) begin
            if (sda_s2_q) begin
              // Master NACK ends the read; busy holds until STOP.
              state_d     = StIdle;
              addressed_d = 1'b0;
            end
          end else if (sclk_fall) begin
            cnt_d     = 3'd0;
            shreg_d   = tx_data;
            tx_load_d = 1'b1;
            sda_oe_d  = ~tx_bit(tx_data);
            state_d   = StTx;
          end
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      shreg_q     <= 8'h00;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  // Gating with rst releases the bus combinationally, ahead of the flop reset.
  assign sda       = (sda_oe_q && !rst) ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_load   = tx_load_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, queue scoreboard for rx bytes and tx loads.
module tb_i2c_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Master side; sel routes the master to dut0 (MSB first) or dut1 (LSB first).
  logic sclk_m, m_oe, sel;
  logic sclk0, sclk1;
  wire  sda0, sda1;
  assign sclk0 = sel ? 1'b1 : sclk_m;
  assign sclk1 = sel ? sclk_m : 1'b1;
  assign sda0  = (m_oe && !sel) ? 1'b0 : 1'bz;
  assign sda1  = (m_oe && sel) ? 1'b0 : 1'bz;
  pullup (sda0);
  pullup (sda1);

  logic [7:0] tx_data;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1, tx_load0, tx_load1;
  logic       busy0, busy1, addressed0, addressed1;

  i2c_slave #(.SLAVE_ADDR(7'h77), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .sda(sda0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_data(tx_data), .tx_load(tx_load0), .busy(busy0), .addressed(addressed0)
  );

  i2c_slave #(.SLAVE_ADDR(7'h77), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .sda(sda1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_data(tx_data), .tx_load(tx_load1), .busy(busy1), .addressed(addressed1)
  );

  logic bus_sda, busy_s, addressed_s;
  assign bus_sda     = sel ? sda1 : sda0;
  assign busy_s      = sel ? busy1 : busy0;
  assign addressed_s = sel ? addressed1 : addressed0;

  int total = 0;
  int bad   = 0;
  int loads = 0;
  logic drove;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_plan[$];
  logic [7:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents rx_valid / tx_load.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid0 || rx_valid1) begin
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_valid_unexpected: got pulse with rx_data %0h want none",
                   sel ? rx_data1 : rx_data0);
        end else begin
          check("rx_data", sel ? rx_data1 : rx_data0, exp_rx.pop_front());
        end
      end
      if (tx_load0 || tx_load1) begin
        loads++;
        if (tx_plan.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_load_unexpected: got pulse want none");
        end else begin
          void'(tx_plan.pop_front());
        end
        // Upstream is free to change tx_data once it has been captured.
        tx_data = (tx_plan.size() != 0) ? tx_plan[0] : 8'($urandom);
      end
    end
  end

  // The master only moves on negedges, so posedge sampling sees a settled bus.
  always @(posedge clk) begin
    if (!m_oe && bus_sda === 1'b0) drove = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_oe = 1'b0;
    wait_clk(4);
    sclk_m = 1'b1;
    wait_clk(8);
    m_oe = 1'b1;
    wait_clk(8);
    sclk_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic bus_stop();
    m_oe = 1'b1;
    wait_clk(4);
    sclk_m = 1'b1;
    wait_clk(8);
    m_oe = 1'b0;
    wait_clk(2);
    check("busy_before_stop_det", busy_s, 1);
    wait_clk(1);
    check("busy_after_stop", busy_s, 0);
    check("addressed_after_stop", addressed_s, 0);
    wait_clk(5);
  endtask

  task automatic put_bit(input logic b);
    m_oe = ~b;
    wait_clk(4);
    sclk_m = 1'b1;
    wait_clk(8);
    sclk_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic get_bit(output logic b);
    m_oe = 1'b0;
    wait_clk(4);
    sclk_m = 1'b1;
    wait_clk(4);
    b = bus_sda;
    wait_clk(4);
    sclk_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit lsb, output logic ack);
    for (int i = 0; i < 8; i++) put_bit(lsb ? b[i] : b[7-i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic x;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(x);
      b[7-i] = x;
    end
  endtask

  task automatic plan_tx(input logic [7:0] b);
    if (tx_plan.size() == 0) tx_data = b;
    tx_plan.push_back(b);
    exp_rd.push_back(b);
  endtask

  // Reference behaviour: only address 7'h77 ACKs; an ACKed write delivers each data byte once.
  task automatic txn_write(input logic [6:0] addr, input logic [7:0] d0, input int n,
                           input bit lsb);
    logic       hit, a;
    logic [7:0] d;
    hit   = (addr == 7'h77);
    drove = 1'b0;
    bus_start();
    check("wr_busy", busy_s, 1);
    write_byte({addr, 1'b0}, lsb, a);
    check("wr_addr_ack", a, !hit);
    check("wr_addressed", addressed_s, hit);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : 8'($urandom);
      if (hit) exp_rx.push_back(d);
      write_byte(d, lsb, a);
      check("wr_data_ack", a, !hit);
    end
    bus_stop();
    check("wr_drove", drove, hit);
  endtask

  // Reads n planned bytes from 7'h77 on dut0, ACKing all but the last.
  task automatic txn_read(input int n);
    int         l0;
    logic       a;
    logic [7:0] b;
    l0 = loads;
    bus_start();
    check("rd_busy", busy_s, 1);
    check("rd_addressed_at_start", addressed_s, 0);
    write_byte({7'h77, 1'b1}, 1'b0, a);
    check("rd_addr_ack", a, 0);
    check("rd_addressed", addressed_s, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      check("rd_data", b, exp_rd.pop_front());
      put_bit(i == n - 1);
    end
    check("rd_released_after_nack", bus_sda, 1);
    check("rd_addressed_after_nack", addressed_s, 0);
    bus_stop();
    check("rd_loads", loads - l0, n);
  endtask

  initial begin
    logic       a;
    logic [6:0] ma;
    int         r, n;
    rst     = 1'b1;
    sel     = 1'b0;
    sclk_m  = 1'b1;
    m_oe    = 1'b0;
    tx_data = 8'h00;
    drove   = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("rst_rx_data", rx_data0, 8'h00);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_tx_load", tx_load0, 0);
    check("rst_busy", busy0, 0);
    check("rst_addressed", addressed0, 0);
    check("rst_sda", bus_sda, 1);

    txn_write(7'h77, 8'hA5, 1, 1'b0);
    txn_write(7'h12, 8'h5C, 1, 1'b0);
    plan_tx(8'h3C);
    plan_tx(8'hC3);
    txn_read(2);

    // Repeated START after 4 bits of a write data byte, then a normal read.
    bus_start();
    write_byte({7'h77, 1'b0}, 1'b0, a);
    check("rs_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom));
    plan_tx(8'($urandom));
    txn_read(1);

    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      if (r == 0) begin
        txn_write(7'h77, 8'($urandom), n, 1'b0);
      end else if (r == 1) begin
        ma = 7'($urandom);
        if (ma == 7'h77) ma = 7'h76;
        txn_write(ma, 8'($urandom), n, 1'b0);
      end else begin
        for (int i = 0; i < n; i++) plan_tx(8'($urandom));
        txn_read(n);
      end
    end

    // LSB-first target.
    sel = 1'b1;
    wait_clk(4);
    txn_write(7'h77, 8'h01, 1, 1'b1);
    sel = 1'b0;
    wait_clk(4);

    // Reset while the target holds the address ACK low.
    txn_write(7'h77, 8'h5A, 1, 1'b0);
    bus_start();
    for (int i = 0; i < 8; i++) put_bit(r == 99 ? 1'b0 : (8'hEE >> (7 - i)) & 8'h01);
    m_oe = 1'b0;
    wait_clk(4);
    sclk_m = 1'b1;
    wait_clk(4);
    check("ack_before_rst", bus_sda, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_sda_release", bus_sda, 1);
    check("rst2_rx_data", rx_data0, 8'h00);
    check("rst2_rx_valid", rx_valid0, 0);
    check("rst2_tx_load", tx_load0, 0);
    check("rst2_busy", busy0, 0);
    check("rst2_addressed", addressed0, 0);
    @(negedge clk);
    sclk_m = 1'b0;
    wait_clk(4);
    m_oe = 1'b1;
    wait_clk(4);
    sclk_m = 1'b1;
    wait_clk(4);
    m_oe = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    check("post_rst_busy", busy0, 0);
    txn_write(7'h77, 8'($urandom), 2, 1'b0);

    wait_clk(10);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_plan_drained", tx_plan.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Byte-oriented I2C target that sits on the far side of the `sclk`/`sda` bus driven by the team's I2C master. It oversamples the bus with the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs its address and all written bytes, and hands received bytes to local logic. For reads it fetches transmit bytes from local logic. Release of `sda` models the open-drain bus.

## Interface
- `SLAVE_ADDR`, 7'h77: 7-bit address; the master's 8'hee address byte corresponds to this value.
- `LSB_FIRST`, 0: bit order on the wire. 0 = MSB first; 1 = LSB first, matching the codebase master.
- `clk`  in  1  system clock; all state advances on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `sclk`  in  1  bus clock from master.
- `sda`  inout  1  bus data; driven 1'b0 or 1'bz only, never 1'b1.
- `rx_data`  out  8  last byte written by master (data phase only; address byte excluded).
- `rx_valid`  out  1  one-`clk` pulse when `rx_data` updates.
- `tx_data`  in  8  byte to return on reads; must be stable when `tx_load` pulses.
- `tx_load`  out  1  one-`clk` pulse when `tx_data` is captured; upstream may change `tx_data` afterwards.
- `busy`  out  1  high from START detect to STOP detect (any address).
- `addressed`  out  1  high from address ACK until STOP, repeated START, or read NACK.

## Operation
- Front end: 2-flop synchronizers on `sclk` and `sda`, plus a registered previous sample for edge detection.
- START is synchronized `sda` 1→0 with `sclk` high in both current and previous sample. STOP is `sda` 0→1 under the same qualification.
- START/STOP take priority over every state. Any cycle showing a simultaneous `sclk` edge is treated as an `sclk` edge, not START/STOP.
- Data is sampled on synchronized `sclk` rising edges. The slave changes its `sda` drive only on synchronized `sclk` falling edges.
- States:
  - IDLE: ignores `sclk`. START → ADDR.
  - ADDR: shifts 8 bits (7 address + R/W, bit order per `LSB_FIRST`), then evaluates on the 8th rising edge.
    - Mismatch → IDLE; no drive until the next START.
    - Match → on the next falling edge drive `sda` low and go to ADDR_ACK.
  - ADDR_ACK: on the following falling edge release `sda`.
    - R/W=0 → RX.
    - R/W=1 → TX. The same falling edge captures `tx_data`, pulses `tx_load` and drives the first bit.
  - RX: samples 8 bits. On the 8th rising edge, `rx_data` ← shift register and `rx_valid` pulses. The next falling edge drives ACK (low) → RX_ACK.
  - RX_ACK: next falling edge releases `sda` → RX.
  - TX: drives bit n on each falling edge; a 1 bit is driven as z. After the 8th bit's falling edge period ends, the next falling edge releases `sda` → TX_ACK.
  - TX_ACK: samples the master's response on the rising edge.
    - 0 (ACK): on the next falling edge capture `tx_data`, pulse `tx_load`, drive bit 0 → TX.
    - 1 (NACK): go to IDLE with `sda` released; `busy` stays high until STOP.
- Repeated START in any state: release `sda`, clear the bit counter, → ADDR. `rx_valid`/`tx_load` are not issued for the partial byte.
- STOP in any state: release `sda`, → IDLE, `busy`=0, `addressed`=0. A partial byte is discarded.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

## Timing
- Reset values: `sda` = z, `rx_data` = 8'h00, `rx_valid` = 0, `tx_load` = 0, `busy` = 0, `addressed` = 0, state IDLE, counter 0.
- Assertion of `rst` releases `sda` immediately, without waiting for `clk`.
- Pin change to detection: 3 `clk` cycles. Detection to `sda` drive change: registered, so it is visible on the same edge that records detection (3 `clk` after the `sclk` pin edge).
- `rx_valid` rises 3 `clk` after the 8th data rising edge on the pin.
- Requirement: `sclk` high and low phases are each ≥ 4 `clk` cycles, and master `sda` setup/hold about `sclk` edges is ≥ 3 `clk`.

## Test plan
- Write to 7'h77, MSB-first, data 8'hA5:
  - ACK low during the 9th `sclk` of both the address and data bytes.
  - `rx_data`=8'hA5 with a single `rx_valid` pulse.
  - `busy` falls 3 `clk` after STOP.
- Address 7'h12: no `sda` drive for the whole transaction; `addressed` stays 0; `rx_valid` never pulses.
- Read from 7'h77 with `tx_data`=8'h3C, then master ACK, then `tx_data`=8'hC3 and master NACK:
  - Bus shows 3C then C3.
  - Two `tx_load` pulses.
  - `sda` released after the NACK.
- `LSB_FIRST`=1, master address byte 8'hee sent LSB first, write 8'h01: ACK is given and `rx_data`=8'h01.
- Repeated START after 4 bits of a write data byte, followed by a read: no `rx_valid` for the partial byte; the read proceeds normally.
- `rst` asserted while the slave drives the ACK low: `sda` goes z within the same `clk` period, and all outputs return to their reset values.
